// File: rtl/control_fsm.sv
// Multi-cycle control unit for the 16-bit CR16-subset datapath.
// It captures each instruction word into IR during DECODE and drives the
// register file addresses and write enable. It also drives the ALU,
// immediate, memory and PC controls, and holds the compare flags that
// conditional branches read.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | memory read at PC; instruction word returns next cycle
// DECODE | instruction word from memory is latched into IR
// EXEC   | controls decoded from IR; PC advances unless the op is LOAD
// MEMWB  | LOAD only: memory data written back to Rdest, PC advances
module control_fsm (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr,
   input  logic [2:0]  flagsIn,
   output logic [3:0]  srcAddr,
   output logic [3:0]  dstAddr,
   output logic        writeEn,
   output logic        wbSel,
   output logic [2:0]  aluOp,
   output logic        useImm,
   output logic [15:0] immediate,
   output logic        memRead,
   output logic        memWrite,
   output logic        addrSel,
   output logic        pcEn,
   output logic        pcSel,
   output logic [15:0] brDisp,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DECODE = 2'd1,
      EXEC   = 2'd2,
      MEMWB  = 2'd3
   } stateT;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_AND   = 3'd2;
   localparam logic [2:0] ALU_OR    = 3'd3;
   localparam logic [2:0] ALU_XOR   = 3'd4;
   localparam logic [2:0] ALU_PASSB = 3'd5;

   localparam logic [3:0] OP_RTYPE  = 4'b0000;
   localparam logic [3:0] OP_MEM    = 4'b0100;
   localparam logic [3:0] OP_BCOND  = 4'b1100;
   localparam logic [3:0] OP_LUI    = 4'b1111;

   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;

   stateT       curState;
   stateT       nextState;
   logic [15:0] ir;
   logic [2:0]  flags;

   logic [3:0]  opcode;
   logic [3:0]  extCode;
   logic [3:0]  condCode;

   logic        opAlu;
   logic        opImm;
   logic        opCmp;
   logic        opLoad;
   logic        opStor;
   logic        opBranch;
   logic [2:0]  decAluOp;
   logic [15:0] immExt;
   logic        brTaken;

   logic        flagZ;
   logic        flagLt;
   logic        flagLo;

   assign opcode   = ir[15:12];
   assign extCode  = ir[7:4];
   assign condCode = ir[11:8];

   assign flagZ    = flags[2];
   assign flagLt   = flags[1];
   assign flagLo   = flags[0];

   // Register addresses and branch displacement follow IR at all times.
   assign srcAddr  = ir[3:0];
   assign dstAddr  = ir[11:8];
   assign brDisp   = {{8{ir[7]}}, ir[7:0]};
   assign state    = curState;

   // Instruction class decode; R-type and immediate forms share function codes.
   always_comb begin
      opAlu    = 1'b0;
      opImm    = 1'b0;
      opCmp    = 1'b0;
      opLoad   = 1'b0;
      opStor   = 1'b0;
      opBranch = 1'b0;
      decAluOp = ALU_ADD;
      immExt   = 16'h0000;
      if (opcode == OP_RTYPE) begin
         case (extCode)
            4'b0101: begin opAlu = 1'b1; decAluOp = ALU_ADD;   end
            4'b1001: begin opAlu = 1'b1; decAluOp = ALU_SUB;   end
            4'b0001: begin opAlu = 1'b1; decAluOp = ALU_AND;   end
            4'b0010: begin opAlu = 1'b1; decAluOp = ALU_OR;    end
            4'b0011: begin opAlu = 1'b1; decAluOp = ALU_XOR;   end
            4'b1101: begin opAlu = 1'b1; decAluOp = ALU_PASSB; end
            4'b1011: begin opAlu = 1'b1; opCmp = 1'b1; decAluOp = ALU_SUB; end
            default: ;
         endcase
      end else if (opcode == OP_MEM) begin
         if (extCode == EXT_LOAD) begin
            opLoad = 1'b1;
         end else if (extCode == EXT_STOR) begin
            opStor = 1'b1;
         end
      end else if (opcode == OP_BCOND) begin
         opBranch = 1'b1;
      end else begin
         // Arithmetic immediates sign-extend; logical immediates and MOVI
         // zero-extend so masks and small constants load unchanged.
         case (opcode)
            4'b0101: begin
               opAlu = 1'b1; opImm = 1'b1; decAluOp = ALU_ADD;
               immExt = {{8{ir[7]}}, ir[7:0]};
            end
            4'b1001: begin
               opAlu = 1'b1; opImm = 1'b1; decAluOp = ALU_SUB;
               immExt = {{8{ir[7]}}, ir[7:0]};
            end
            4'b0001: begin
               opAlu = 1'b1; opImm = 1'b1; decAluOp = ALU_AND;
               immExt = {8'h00, ir[7:0]};
            end
            4'b0010: begin
               opAlu = 1'b1; opImm = 1'b1; decAluOp = ALU_OR;
               immExt = {8'h00, ir[7:0]};
            end
            4'b0011: begin
               opAlu = 1'b1; opImm = 1'b1; decAluOp = ALU_XOR;
               immExt = {8'h00, ir[7:0]};
            end
            4'b1101: begin
               opAlu = 1'b1; opImm = 1'b1; decAluOp = ALU_PASSB;
               immExt = {8'h00, ir[7:0]};
            end
            4'b1011: begin
               opAlu = 1'b1; opImm = 1'b1; opCmp = 1'b1; decAluOp = ALU_SUB;
               immExt = {{8{ir[7]}}, ir[7:0]};
            end
            OP_LUI: begin
               opAlu = 1'b1; opImm = 1'b1; decAluOp = ALU_PASSB;
               immExt = {ir[7:0], 8'h00};
            end
            default: ;
         endcase
      end
   end

   // Branch condition evaluated against the stored compare flags.
   always_comb begin
      brTaken = 1'b0;
      case (condCode)
         4'b0000: brTaken = flagZ;
         4'b0001: brTaken = ~flagZ;
         4'b0010: brTaken = flagLt;
         4'b0011: brTaken = ~flagLt;
         4'b0100: brTaken = flagLo;
         4'b0101: brTaken = ~flagLo;
         4'b1110: brTaken = 1'b1;
         default: brTaken = 1'b0;
      endcase
   end

   // Next-state and control outputs; every output is zero unless the state asserts it.
   always_comb begin
      nextState = curState;
      writeEn   = 1'b0;
      wbSel     = 1'b0;
      aluOp     = ALU_ADD;
      useImm    = 1'b0;
      immediate = 16'h0000;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      addrSel   = 1'b0;
      pcEn      = 1'b0;
      pcSel     = 1'b0;
      case (curState)
         FETCH: begin
            memRead   = 1'b1;
            nextState = DECODE;
         end
         DECODE: begin
            nextState = EXEC;
         end
         EXEC: begin
            if (opLoad) begin
               memRead   = 1'b1;
               addrSel   = 1'b1;
               nextState = MEMWB;
            end else begin
               pcEn      = 1'b1;
               nextState = FETCH;
               if (opStor) begin
                  memWrite = 1'b1;
                  addrSel  = 1'b1;
               end
               if (opAlu) begin
                  aluOp     = decAluOp;
                  useImm    = opImm;
                  immediate = immExt;
                  writeEn   = ~opCmp;
               end
               if (opBranch) begin
                  pcSel = brTaken;
               end
            end
         end
         MEMWB: begin
            writeEn   = 1'b1;
            wbSel     = 1'b1;
            pcEn      = 1'b1;
            nextState = FETCH;
         end
         default: nextState = FETCH;
      endcase
   end

   // State register; reset forces FETCH asynchronously so pending writes drop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         curState <= FETCH;
      end else begin
         curState <= nextState;
      end
   end

   // Instruction register, loaded only in DECODE when memory data is valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir <= 16'h0000;
      end else if (curState == DECODE) begin
         ir <= instr;
      end
   end

   // Compare flags, updated only by CMP/CMPI at the end of EXEC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags <= 3'b000;
      end else if (curState == EXEC && opCmp) begin
         flags <= flagsIn;
      end
   end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control unit for the 16-bit CR16-subset datapath. It sits directly upstream of `registerFile`. It captures each instruction word from memory and drives the register file's `srcAddr`/`dstAddr`/`writeEn` together with ALU, immediate, memory and PC controls. It also holds the compare flags used by conditional branches.

## Interface
- No parameters; data width 16, register address width 4.
- `clk` in 1: single clock, all state changes on rising edge.
- `reset` in 1: asynchronous, active-low.
- `instr` in 16: memory read data. Synchronous memory, so it is valid the cycle after the address is presented.
- `flagsIn` in 3: `{Z, LT, LO}` from ALU compare of Rdest vs Rsrc/imm, valid in EXEC. Z = equal, LT = Rdest < operand signed, LO = Rdest < operand unsigned.
- `srcAddr` out 4: register file read port 2 address (IR[3:0]).
- `dstAddr` out 4: register file read port 1 and write address (IR[11:8]).
- `writeEn` out 1: register file write enable.
- `wbSel` out 1: writeback source, 0 = ALU, 1 = memory.
- `aluOp` out 3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASSB.
- `useImm` out 1: ALU B operand, 1 = `immediate`, 0 = readData2.
- `immediate` out 16: extended IR[7:0].
- `memRead` out 1, `memWrite` out 1.
- `addrSel` out 1: memory address, 0 = PC, 1 = readData2.
- `pcEn` out 1, `pcSel` out 1: PC update, 0 = PC+1, 1 = PC+`brDisp`.
- `brDisp` out 16: sign-extended IR[7:0].
- `state` out 2: debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEMWB=3.
- FETCH: `memRead`=1, `addrSel`=0. Next state DECODE.
- DECODE: IR <= `instr` at the end of the cycle. Next state EXEC.
- EXEC: all controls decode from IR.
- EXEC transitions: LOAD goes to MEMWB; everything else goes to FETCH with `pcEn`=1.
- MEMWB (LOAD only): `writeEn`=1, `wbSel`=1, `pcEn`=1, `pcSel`=0. Next state FETCH.
- R-type (IR[15:12]=0000), function in IR[7:4]: 0101 ADD, 1001 SUB, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV (PASSB), 1011 CMP (SUB).
- Immediate types use IR[15:12] with the same codes as R-type functions, plus 1111 LUI. `useImm`=1 for all immediate types.
- Immediate extension:
  - ADDI, SUBI, CMPI: sign-extend.
  - ANDI, ORI, XORI, MOVI: zero-extend.
  - LUI: `{IR[7:0], 8'h00}` with PASSB.
- ALU and immediate instructions other than CMP/CMPI: `writeEn`=1, `wbSel`=0 in EXEC.
- CMP/CMPI: `writeEn`=0; flags register <= `flagsIn` at the end of EXEC. No other instruction modifies the flags.
- LOAD (0100, ext 0000) is `Rdest <- M[Rsrc]`. EXEC: `memRead`=1, `addrSel`=1.
- STOR (0100, ext 0100) is `M[Rsrc] <- Rdest` (readData1). EXEC: `memWrite`=1, `addrSel`=1, `writeEn`=0.
- Bcond (1100), cond = IR[11:8]: 0000 EQ (Z), 0001 NE (!Z), 0010 LT, 0011 GE (!LT), 0100 LO, 0101 HS (!LO), 1110 always. All other codes are never taken.
- Bcond in EXEC: `pcSel`=taken; no register or memory write.
- Any other encoding is a NOP: EXEC with all writes 0, PC+1.
- Outputs default to 0 in every state unless listed above. `srcAddr`/`dstAddr` always reflect IR.

## Timing
- Instruction latency: ALU/CMP/STOR/Bcond/NOP 3 cycles; LOAD 4 cycles.
- Register writes take effect at the rising edge ending EXEC (MEMWB for LOAD).
- Reset asserted (low) at any time, including mid-instruction:
  - state immediately becomes FETCH, IR = 16'h0000, flags = 3'b000;
  - every output is 0 except FETCH's `memRead`=1;
  - pending writes are dropped. The PC block is reset separately.
- Reset release: the first FETCH occupies the first full cycle after deassertion.
- The flag update from CMP in EXEC is visible to a Bcond whose EXEC is 3 cycles later (no hazard, since the design is non-pipelined).
- Decoding uses IR only, never `instr` directly, so `instr` changing outside DECODE has no effect.

## Test plan
- Reset mid-EXEC of ADD: pull `reset` low → `writeEn` drops to 0 asynchronously and `state`=0. After release, FETCH → DECODE → EXEC are seen in 3 cycles.
- ADD R1,R2 (16'h0152): EXEC has `dstAddr`=1, `srcAddr`=2, `aluOp`=0, `useImm`=0, `writeEn`=1, `pcEn`=1, `pcSel`=0; next state FETCH.
- ADDI R3,#-2 (16'h53FE): `immediate`=16'hFFFE, `useImm`=1. LUI R3,#8'hAB (16'hF3AB): `immediate`=16'hAB00, `aluOp`=5.
- LOAD R4,[R5] (16'h4405): EXEC `memRead`=1, `addrSel`=1, `writeEn`=0. MEMWB `writeEn`=1, `wbSel`=1. Total 4 cycles.
- STOR R6,[R7] (16'h4647): EXEC `memWrite`=1, `addrSel`=1, `dstAddr`=6, `srcAddr`=7, `writeEn`=0.
- CMP R1,R2 with `flagsIn`=3'b100, then BEQ +5 (16'hC005) → `pcEn`=1, `pcSel`=1, `brDisp`=5. With `flagsIn`=3'b000 → `pcSel`=0. BNE -3 (16'hC1FD) after Z=0 → `pcSel`=1, `brDisp`=16'hFFFD.
